// File: rtl/image_pkg.sv
// Shared definitions for the image byte-stream front end and the downstream
// image-processing stage: marker bytes, parser states, error codes, geometry.
package image_pkg;

    localparam logic [7:0] MARK_FF    = 8'hFF;
    localparam logic [7:0] MARK_SOI   = 8'hD8;
    localparam logic [7:0] MARK_EOI   = 8'hD9;
    localparam logic [7:0] MARK_STUFF = 8'h00;

    localparam int IMG_WIDTH_DEFAULT  = 320;
    localparam int IMG_HEIGHT_DEFAULT = 240;

    localparam logic [1:0] ERR_NONE       = 2'd0;
    localparam logic [1:0] ERR_BAD_MARKER = 2'd1;
    localparam logic [1:0] ERR_EARLY_EOI  = 2'd2;
    localparam logic [1:0] ERR_RESTART    = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SOI_FF,
        ST_DATA,
        ST_DATA_FF,
        ST_TRAIL,
        ST_TRAIL_FF
    } state_e;

endpackage

// File: rtl/image_stream_deframer_pix_out_stage.sv
// Valid/ready output register for the pixel stream: holds pixel value,
// coordinates and frame/line flags stable until the consumer accepts them.
module pix_out_stage #(
    parameter int XW = 9,
    parameter int YW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load_i,
    input  logic [7:0]    data_i,
    input  logic [XW-1:0] x_i,
    input  logic [YW-1:0] y_i,
    input  logic          sof_i,
    input  logic          eol_i,
    input  logic          eof_i,
    input  logic          ready_i,
    output logic          valid_o,
    output logic [7:0]    data_o,
    output logic [XW-1:0] x_o,
    output logic [YW-1:0] y_o,
    output logic          sof_o,
    output logic          eol_o,
    output logic          eof_o
);

    logic          valid_q;
    logic [7:0]    data_q;
    logic [XW-1:0] x_q;
    logic [YW-1:0] y_q;
    logic          sof_q, eol_q, eof_q;

    // load_i is only raised when the slot is free or being drained this cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            x_q     <= '0;
            y_q     <= '0;
            sof_q   <= 1'b0;
            eol_q   <= 1'b0;
            eof_q   <= 1'b0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            data_q  <= data_i;
            x_q     <= x_i;
            y_q     <= y_i;
            sof_q   <= sof_i;
            eol_q   <= eol_i;
            eof_q   <= eof_i;
        end else if (ready_i) begin
            valid_q <= 1'b0;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign x_o     = x_q;
    assign y_o     = y_q;
    assign sof_o   = sof_q;
    assign eol_o   = eol_q;
    assign eof_o   = eof_q;

endmodule

// File: rtl/image_stream_deframer.sv
// Marker-delimited byte stream to raster pixel stream: hunts SOI, removes
// FF 00 stuffing, tags pixels with x/y and flags, and checks frame length.
module image_stream_deframer
    import image_pkg::*;
#(
    parameter int IMG_WIDTH  = IMG_WIDTH_DEFAULT,
    parameter int IMG_HEIGHT = IMG_HEIGHT_DEFAULT
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [7:0]                    in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic [7:0]                    pix_data,
    output logic                          pix_valid,
    input  logic                          pix_ready,
    output logic [$clog2(IMG_WIDTH)-1:0]  pix_x,
    output logic [$clog2(IMG_HEIGHT)-1:0] pix_y,
    output logic                          pix_sof,
    output logic                          pix_eol,
    output logic                          pix_eof,
    output logic                          frame_done,
    output logic                          frame_err,
    output logic [1:0]                    err_code
);

    localparam int XW = $clog2(IMG_WIDTH);
    localparam int YW = $clog2(IMG_HEIGHT);
    localparam logic [XW-1:0] X_LAST = XW'(IMG_WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IMG_HEIGHT - 1);

    state_e        state_q, state_d;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic [1:0]    err_code_q, err_code_d;
    logic          rdy_en_q;

    logic       accept, emit, clear;
    logic [7:0] emit_data;
    logic       last_col, last_row;

    // rdy_en_q keeps in_ready low throughout reset and for the first edge after it
    assign in_ready = rdy_en_q && (!pix_valid || pix_ready);
    assign accept   = in_valid && in_ready;
    assign last_col = (x_q == X_LAST);
    assign last_row = (y_q == Y_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            x_q        <= '0;
            y_q        <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= ERR_NONE;
            rdy_en_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            y_q        <= y_d;
            done_q     <= done_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
            rdy_en_q   <= 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        y_d        = y_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        err_code_d = err_code_q;
        emit       = 1'b0;
        emit_data  = in_data;
        clear      = 1'b0;
        if (accept) begin
            unique case (state_q)
                ST_IDLE: if (in_data == MARK_FF) state_d = ST_SOI_FF;
                ST_SOI_FF: begin
                    if (in_data == MARK_SOI) begin
                        state_d = ST_DATA;
                        clear   = 1'b1;
                    end else if (in_data != MARK_FF) begin
                        state_d = ST_IDLE;
                    end
                end
                ST_DATA: begin
                    if (in_data == MARK_FF) state_d = ST_DATA_FF;
                    else                    emit    = 1'b1;
                end
                ST_DATA_FF: begin
                    case (in_data)
                        MARK_STUFF: begin
                            emit      = 1'b1;
                            emit_data = MARK_FF;
                            state_d   = ST_DATA;
                        end
                        MARK_SOI: begin
                            err_d = 1'b1; err_code_d = ERR_RESTART;
                            clear = 1'b1; state_d = ST_DATA;
                        end
                        MARK_EOI: begin
                            err_d = 1'b1; err_code_d = ERR_EARLY_EOI; state_d = ST_IDLE;
                        end
                        default: begin
                            err_d = 1'b1; err_code_d = ERR_BAD_MARKER; state_d = ST_IDLE;
                        end
                    endcase
                end
                ST_TRAIL: begin
                    if (in_data == MARK_FF) begin
                        state_d = ST_TRAIL_FF;
                    end else begin
                        err_d = 1'b1; err_code_d = ERR_RESTART; state_d = ST_IDLE;
                    end
                end
                ST_TRAIL_FF: begin
                    if (in_data == MARK_EOI) begin
                        done_d = 1'b1; state_d = ST_IDLE;
                    end else if (in_data == MARK_SOI) begin
                        err_d = 1'b1; err_code_d = ERR_RESTART;
                        clear = 1'b1; state_d = ST_DATA;
                    end else begin
                        err_d = 1'b1; err_code_d = ERR_RESTART; state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
            // the last pixel of the frame leaves the parser waiting for EOI
            if (emit) begin
                if (last_col) begin
                    x_d = '0;
                    if (last_row) begin
                        y_d     = '0;
                        state_d = ST_TRAIL;
                    end else begin
                        y_d = y_q + 1'b1;
                    end
                end else begin
                    x_d = x_q + 1'b1;
                end
            end
            if (clear) begin
                x_d = '0;
                y_d = '0;
            end
        end
    end

    pix_out_stage #(.XW(XW), .YW(YW)) u_out (
        .clk     (clk),
        .reset   (reset),
        .load_i  (emit),
        .data_i  (emit_data),
        .x_i     (x_q),
        .y_i     (y_q),
        .sof_i   ((x_q == '0) && (y_q == '0)),
        .eol_i   (last_col),
        .eof_i   (last_col && last_row),
        .ready_i (pix_ready),
        .valid_o (pix_valid),
        .data_o  (pix_data),
        .x_o     (pix_x),
        .y_o     (pix_y),
        .sof_o   (pix_sof),
        .eol_o   (pix_eol),
        .eof_o   (pix_eof)
    );

    assign frame_done = done_q;
    assign frame_err  = err_q;
    assign err_code   = err_code_q;

endmodule

// File: doc/image_stream_deframer.md
# image_stream_deframer

Byte-stream front end that sits directly upstream of the image-processing stage: it hunts for a JPEG-style start-of-image marker, strips marker bytes and byte-stuffing, and emits a raster-ordered pixel stream tagged with x/y coordinates and frame/line flags. It checks frame length against the configured geometry and closes each frame on an end-of-image marker. Malformed streams are reported and resynchronised.

## Interface
- IMG_WIDTH, 320, pixels per line
- IMG_HEIGHT, 240, lines per frame
- clk  in  1  system clock, all logic rising-edge
- reset  in  1  asynchronous, active-low; the block is held in reset while low
- in_data  in  8  raw stream byte
- in_valid  in  1  in_data valid
- in_ready  out  1  byte accepted when in_valid && in_ready
- pix_data  out  8  pixel value
- pix_valid  out  1  pixel output valid
- pix_ready  in  1  downstream accepts when pix_valid && pix_ready
- pix_x  out  $clog2(IMG_WIDTH)  column of pix_data
- pix_y  out  $clog2(IMG_HEIGHT)  line of pix_data
- pix_sof / pix_eol / pix_eof  out  1 each  first pixel of frame / last of line / last of frame
- frame_done  out  1  one-cycle pulse on a valid EOI
- frame_err  out  1  one-cycle pulse on any protocol error
- err_code  out  2  1 = bad marker, 2 = early EOI, 3 = SOI restart/missing EOI; held until next error

## Operation
- Markers: SOI = FF D8, EOI = FF D9, stuffing FF 00 → one pixel of value FF.
- States: IDLE (discard until FF) → SOI_FF (D8 → DATA; FF stays; other → IDLE). DATA (non-FF → emit pixel; FF → DATA_FF). DATA_FF (00 → emit FF; D8 → err 3, counters cleared, DATA; D9 → err 2, IDLE; other → err 1, IDLE). After emitting pixel W·H−1 → TRAIL. TRAIL (FF → TRAIL_FF; other → err 3, IDLE). TRAIL_FF (D9 → frame_done, IDLE; D8 → err 3, counters cleared, DATA; other → err 3, IDLE).
- Counters: x increments per emitted pixel, wraps at IMG_WIDTH−1 to 0 with y+1; both cleared on SOI and reset. pix_sof = (x==0 && y==0); pix_eol = (x==IMG_WIDTH−1); pix_eof = eol && (y==IMG_HEIGHT−1).
- Only DATA/DATA_FF emit pixels; markers and the FF of a stuffing pair never emit.
- err_code and frame_err update in the same cycle the offending byte is accepted.

## Timing
- Reset values: in_ready 0 while reset low, 1 one cycle after release with empty output; pix_valid, frame_done, frame_err 0; pix_data, pix_x, pix_y, flags, err_code 0; state IDLE.
- Output is a single register stage: byte accepted in cycle N → pix_valid in N+1.
- in_ready = !pix_valid || pix_ready (combinational); applies in every state, so stalls freeze marker parsing too.
- pix_valid holds with all output fields stable until accepted; back-to-back throughput 1 pixel/cycle with pix_ready high.
- frame_done/frame_err pulse in N+1 for the byte accepted in N, independent of pix_ready.
- Reset asserted mid-frame: output and state cleared immediately; a partially delivered frame is abandoned without error.

## Structure
- Shared package image_pkg: SOI/EOI/stuffing byte constants, state enum, err_code constants, IMG_WIDTH/IMG_HEIGHT defaults shared with the image-processing stage.
- One sub-module natural: pix_out_stage (valid/ready output register holding pix_data, coordinates and flags).

## Test plan (IMG_WIDTH=4, IMG_HEIGHT=2)
- FF D8, bytes 01..08, FF D9 → 8 pixels x/y (0,0)…(3,1), sof on 01, eol on 04 and 08, eof on 08, frame_done once, no frame_err.
- Payload containing FF 00 at pixel 3 → pix_data FF at x=2,y=0; pixel count still 8.
- FF D9 after 5 pixels → frame_err, err_code 2, state IDLE; following bytes ignored until next FF D8.
- FF D8 after 3 pixels → err_code 3, next pixel reported at (0,0) with pix_sof.
- pix_ready low for 4 cycles mid-frame → in_ready low, pix_data/pix_x held, no pixel lost or duplicated.
- reset low after 6 pixels, release, full valid frame → pix_valid drops immediately, new frame output identical to scenario 1.
